keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 32 +++
 rtl/sync2.sv | 28 ++
 rtl/keypad_scanner.sv | 116 +++++++++++
 tb/tb_keypad_scanner.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad scanner definitions: FSM states, column drive patterns,
// the idle key code and the column rotation helper.
package keypad_pkg;

    typedef enum logic {
        SCAN = 1'b0,
        HOLD = 1'b1
    } kp_state_t;

    // One-hot active-low column drive patterns, in scan order
    localparam logic [3:0] COL0 = 4'b1110;
    localparam logic [3:0] COL1 = 4'b1101;
    localparam logic [3:0] COL2 = 4'b1011;
    localparam logic [3:0] COL3 = 4'b0111;

    // key_code value whenever no key is captured
    localparam logic [7:0] KEY_IDLE = 8'h0F;

    // Next column in the scan rotation; any corrupt pattern recovers to COL0
    function automatic logic [3:0] next_col(input logic [3:0] cur);
        logic [3:0] nxt;
        case (cur)
            COL0:    nxt = COL1;
            COL1:    nxt = COL2;
            COL2:    nxt = COL3;
            COL3:    nxt = COL0;
            default: nxt = COL0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with parameterised width; both stages reset to
// all-ones, which is the idle level of pulled-up active-low inputs.
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner. Drives one column low at a time, samples the
// synchronized rows once per scan tick, and holds a captured key until its
// row goes high again.
// Optional build macro: KEYPAD_GHOST_REJECT_EN -- when defined, a column
// showing two or more low rows is treated as no key (ghost rejection);
// when undefined, the lowest-index low row wins.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows_n,
    output logic [3:0] cols_n,
    output logic [7:0] key_code,
    output logic       key_pressed
);

    localparam int             CW        = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  TICK_LAST = CW'(TICK_DIV - 1);

    logic [3:0]    w_rows_s;
    logic [3:0]    w_rows_low;
    logic [3:0]    w_row_sel;
    logic          w_capture;
    logic          w_release;
    logic          w_tick;

    logic [CW-1:0] r_count;
    kp_state_t     r_state;
    logic [3:0]    r_row;
    logic [3:0]    r_cols;
    logic [7:0]    r_code;
    logic          r_pressed;

    sync2 #(
        .WIDTH (4)
    ) u_sync2 (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     (rows_n),
        .o_q     (w_rows_s)
    );

    assign w_tick     = (r_count == TICK_LAST);
    assign w_rows_low = ~w_rows_s;
    // Isolate the lowest set bit: lowest-index low row as a one-hot
    assign w_row_sel  = w_rows_low & (~w_rows_low + 4'd1);

`ifdef KEYPAD_GHOST_REJECT_EN
    assign w_capture  = (w_rows_low != 4'd0) &&
                        ((w_rows_low & (w_rows_low - 4'd1)) == 4'd0);
`else
    assign w_capture  = (w_rows_low != 4'd0);
`endif

    // Latched row reads high again once the key is let go
    assign w_release  = ((w_rows_s & r_row) != 4'd0);

    // Free-running scan tick divider
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Scan/hold state machine with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= SCAN;
            r_row     <= '0;
            r_cols    <= COL0;
            r_code    <= KEY_IDLE;
            r_pressed <= 1'b0;
        end else if (w_tick) begin
            case (r_state)
                SCAN: begin
                    if (w_capture) begin
                        r_state   <= HOLD;
                        r_row     <= w_row_sel;
                        r_code    <= {w_row_sel, r_cols};
                        r_pressed <= 1'b1;
                    end else begin
                        r_cols    <= next_col(r_cols);
                    end
                end
                HOLD: begin
                    if (w_release) begin
                        r_state   <= SCAN;
                        r_row     <= '0;
                        r_cols    <= next_col(r_cols);
                        r_code    <= KEY_IDLE;
                        r_pressed <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= SCAN;
                    r_row     <= '0;
                    r_cols    <= COL0;
                    r_code    <= KEY_IDLE;
                    r_pressed <= 1'b0;
                end
            endcase
        end
    end

    assign cols_n      = r_cols;
    assign key_code    = r_code;
    assign key_pressed = r_pressed;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with TICK_DIV=4. A small keypad model
// pulls a row low when a pressed key's column is being driven.
module tb_keypad_scanner;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] rows_n;
    logic [3:0] cols_n;
    logic [7:0] key_code;
    logic       key_pressed;

    // pressed_keys[r*4+c] = key at row r, column c held down
    logic [15:0] pressed_keys = '0;
    // extra row pull-down independent of the matrix, for glitch stimulus
    logic [3:0]  glitch_n = '1;

    int checks   = 0;
    int failures = 0;

    keypad_scanner #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rows_n      (rows_n),
        .cols_n      (cols_n),
        .key_code    (key_code),
        .key_pressed (key_pressed)
    );

    always #5 clk = ~clk;

    always_comb begin
        rows_n = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed_keys[r*4+c] && !cols_n[c])
                    rows_n[r] = 1'b0;
        rows_n = rows_n & glitch_n;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_kp(input logic val, input int budget);
        int n;
        n = 0;
        while (key_pressed !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        logic [3:0] col_seq [4];
        logic [3:0] c0;
        int bad_kp, bad_kc, bad_cols, moves;

        col_seq[0] = 4'b1110;
        col_seq[1] = 4'b1101;
        col_seq[2] = 4'b1011;
        col_seq[3] = 4'b0111;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_cols", cols_n, 4'b1110);
        check_eq("rst_kp", key_pressed, 1'b0);
        check_eq("rst_kc", key_code, 8'h0F);
        reset = 1'b1;

        // Idle scan rotation: column changes every TICK_DIV cycles
        bad_kp = 0;
        bad_kc = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            check_eq($sformatf("scan_cols_%0d", n), cols_n, col_seq[(n / TICK_DIV) % 4]);
            if (key_pressed !== 1'b0) bad_kp++;
            if (key_code !== 8'h0F) bad_kc++;
        end
        check_eq("scan_kp_errs", bad_kp, 0);
        check_eq("scan_kc_errs", bad_kc, 0);

        // Key row2/col1
        pressed_keys[2*4+1] = 1'b1;
        wait_kp(1'b1, 40);
        check_eq("k21_kp", key_pressed, 1'b1);
        check_eq("k21_kc", key_code, 8'b0100_1101);
        check_eq("k21_cols", cols_n, 4'b1101);

        bad_kp = 0;
        bad_kc = 0;
        bad_cols = 0;
        repeat (12) begin
            @(negedge clk);
            if (key_pressed !== 1'b1) bad_kp++;
            if (key_code !== 8'b0100_1101) bad_kc++;
            if (cols_n !== 4'b1101) bad_cols++;
        end
        // Extra keys during hold, same column and another column
        pressed_keys[0*4+3] = 1'b1;
        pressed_keys[0*4+1] = 1'b1;
        repeat (16) begin
            @(negedge clk);
            if (key_pressed !== 1'b1) bad_kp++;
            if (key_code !== 8'b0100_1101) bad_kc++;
            if (cols_n !== 4'b1101) bad_cols++;
        end
        pressed_keys[0*4+3] = 1'b0;
        pressed_keys[0*4+1] = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (key_pressed !== 1'b1) bad_kp++;
            if (key_code !== 8'b0100_1101) bad_kc++;
            if (cols_n !== 4'b1101) bad_cols++;
        end
        check_eq("hold_kp_errs", bad_kp, 0);
        check_eq("hold_kc_errs", bad_kc, 0);
        check_eq("hold_cols_errs", bad_cols, 0);

        // Release: back to scan with column advanced one step
        pressed_keys[2*4+1] = 1'b0;
        wait_kp(1'b0, 2 + TICK_DIV + 2);
        check_eq("rel_kp", key_pressed, 1'b0);
        check_eq("rel_kc", key_code, 8'h0F);
        check_eq("rel_cols", cols_n, 4'b1011);

        // One-cycle row glitch right after a tick is never sampled
        c0 = cols_n;
        for (int n = 0; n < 3 * TICK_DIV && cols_n === c0; n++) @(negedge clk);
        check_eq("glitch_sync", cols_n, 4'b0111);
        glitch_n = 4'b1011;
        @(negedge clk);
        glitch_n = '1;
        bad_kp = 0;
        repeat (12) begin
            @(negedge clk);
            if (key_pressed !== 1'b0) bad_kp++;
        end
        check_eq("glitch_kp_errs", bad_kp, 0);

        // Rows 1 and 3 low in column 0
        pressed_keys[1*4+0] = 1'b1;
        pressed_keys[3*4+0] = 1'b1;
`ifdef KEYPAD_GHOST_REJECT_EN
        bad_kp = 0;
        moves = 0;
        repeat (40) begin
            c0 = cols_n;
            @(negedge clk);
            if (key_pressed !== 1'b0) bad_kp++;
            if (cols_n !== c0) moves++;
        end
        check_eq("ghost_kp_errs", bad_kp, 0);
        check_eq("ghost_kc", key_code, 8'h0F);
        check_eq("ghost_moves", moves, 10);
`else
        wait_kp(1'b1, 40);
        check_eq("multi_kp", key_pressed, 1'b1);
        check_eq("multi_kc", key_code, 8'b0010_1110);
        check_eq("multi_cols", cols_n, 4'b1110);
`endif
        pressed_keys[3*4+0] = 1'b0;
        wait_kp(1'b1, 40);
        check_eq("k10_kp", key_pressed, 1'b1);
        check_eq("k10_kc", key_code, 8'b0010_1110);

        // Reset pulse mid-hold: asynchronous clear, then reacquire
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_kp", key_pressed, 1'b0);
        check_eq("arst_kc", key_code, 8'h0F);
        check_eq("arst_cols", cols_n, 4'b1110);
        @(negedge clk);
        reset = 1'b1;
        bad_kp = 0;
        repeat (TICK_DIV - 1) begin
            @(negedge clk);
            if (key_pressed !== 1'b0) bad_kp++;
        end
        check_eq("reacq_early_errs", bad_kp, 0);
        @(negedge clk);
        check_eq("reacq_kp", key_pressed, 1'b1);
        check_eq("reacq_kc", key_code, 8'b0010_1110);

        pressed_keys = '0;
        wait_kp(1'b0, 20);
        check_eq("final_kp", key_pressed, 1'b0);
        check_eq("final_kc", key_code, 8'h0F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
